// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks a command byte out to the device and checks its ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] tx_err_code,
   output logic       rx_hold,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_SEND      = 3'd2;
   localparam logic [2:0] S_ACK       = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic [2:0]       state;
   logic [9:0]       shift_reg;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;

   logic [1:0]       pad_meta;
   logic [1:0]       pad_sync;
   logic [1:0]       line_filt;
   logic [FLT_W-1:0] filt_cnt [2];

   logic             clk_filt;
   logic             data_filt;
   logic             clk_filt_q;
   logic             fall_edge;
   logic             timed_out;

   // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data; idle bus level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_meta <= 2'b11;
         pad_sync <= 2'b11;
      end else begin
         pad_meta <= {ps2_data_i, ps2_clk_i};
         pad_sync <= pad_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_filt   <= 2'b11;
         filt_cnt[0] <= '0;
         filt_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (pad_sync[i] == line_filt[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
               line_filt[i] <= pad_sync[i];
               filt_cnt[i]  <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + FLT_W'(1);
            end
         end
      end
   end

   assign clk_filt  = line_filt[0];
   assign data_filt = line_filt[1];
   assign fall_edge = clk_filt_q & ~clk_filt;
   assign rx_hold   = tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_filt_q <= 1'b1;
      else        clk_filt_q <= clk_filt;
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_active;

   assign wd_active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
   assign timed_out = wd_active && !fall_edge && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // The restart cycle itself counts, so the abort lands TIMEOUT_CYCLES after the last edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               wd_cnt <= '0;
      else if (fall_edge || state == S_INHIBIT) wd_cnt <= WD_W'(1);
      else if (wd_active && !timed_out)         wd_cnt <= wd_cnt + WD_W'(1);
   end
`else
   logic unused_timeout_cfg;

   assign timed_out          = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         tx_err_code <= 2'b00;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         if (timed_out) begin
            tx_err      <= 1'b1;
            tx_err_code <= 2'b01;
            tx_busy     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (tx_start) begin
                     shift_reg   <= {1'b1, ~^tx_data, tx_data};
                     tx_busy     <= 1'b1;
                     inh_cnt     <= '0;
                     ps2_clk_oe  <= 1'b1;
                     ps2_data_oe <= 1'b0;
                     state       <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                     ps2_clk_oe  <= 1'b0;
                     ps2_data_oe <= 1'b1;
                     bit_cnt     <= '0;
                     state       <= S_SEND;
                  end else begin
                     inh_cnt <= inh_cnt + INH_W'(1);
                  end
               end
               // The stop bit shifts out as a release, so data is free before ACK.
               S_SEND: begin
                  if (fall_edge) begin
                     ps2_data_oe <= ~shift_reg[0];
                     shift_reg   <= {1'b1, shift_reg[9:1]};
                     if (bit_cnt == 4'd9) state <= S_ACK;
                     else                 bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               S_ACK: begin
                  if (fall_edge) begin
                     if (!data_filt) begin
                        state <= S_WAIT_IDLE;
                     end else begin
                        tx_err      <= 1'b1;
                        tx_err_code <= 2'b10;
                        tx_busy     <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                     end
                  end
               end
               S_WAIT_IDLE: begin
                  if (clk_filt && data_filt) begin
                     tx_done <= 1'b1;
                     tx_busy <= 1'b0;
                     state   <= S_IDLE;
                  end
               end
               default: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_busy     <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the transmit counterpart of the keyboard receive path (ps2_drv).
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Runs on clk50M beside ps2_drv and drives the open-drain PS/2 clock and data lines through the pad tristates.
- Exposes a start/busy/done handshake to the system bus and holds off the receiver while a frame is in flight.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the host holds PS/2 clock low before the start bit (100 us at 50 MHz).
- FILTER_LEN, 8: consecutive identical synchronized samples needed to accept a PS/2 line level change (glitch filter).
- TIMEOUT_CYCLES, 1000000: watchdog limit in clk cycles (20 ms); used only with PS2_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (clk50M domain).
- rst_n  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle request; tx_data is sampled when tx_start=1 and tx_busy=0.
- tx_data  in  8  command byte.
- tx_busy  out  1  high from the accept cycle until the cycle tx_done or tx_err pulses.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_err  out  1  one-cycle pulse: frame aborted.
- tx_err_code  out  2  valid with tx_err: 2'b01 timeout, 2'b10 no ACK; holds its value until the next error.
- rx_hold  out  1  equals tx_busy; tells ps2_drv to discard edges.
- ps2_clk_i  in  1  raw PS/2 clock pad level (asynchronous).
- ps2_data_i  in  1  raw PS/2 data pad level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.

Behaviour:
- Reset: all outputs 0; state IDLE; both lines released. Reset is asynchronous, so asserting it mid-frame releases both lines in the same instant.
- Input conditioning:
  - 2-flop synchronizer on each pad input, then a FILTER_LEN-sample filter.
  - fall_edge = one-cycle pulse when the filtered clock goes 1->0.
- Shift register: {stop=1, parity, data[7:0]}, shifted LSB first. Parity is odd: parity = ~^tx_data.
- State machine:
  - IDLE: on tx_start, latch data, set tx_busy, go to INHIBIT. tx_start while busy is ignored; no queueing.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles (counter). Then ps2_data_oe=1 (start bit) and ps2_clk_oe=0 in the same cycle; go to SEND.
  - SEND: bit counter 0..9. On each fall_edge, ps2_data_oe = ~next bit, in order d0..d7, parity, stop. The stop bit releases data. After the 10th fall_edge, go to ACK.
  - ACK: on the next (11th) fall_edge, sample filtered data.
    - 0: go to WAIT_IDLE.
    - 1: pulse tx_err with code 2'b10, release both lines, go to IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and data=1. Then pulse tx_done, clear tx_busy, go to IDLE.
- Completion timing: tx_busy falls in the same cycle tx_done/tx_err pulses. A new tx_start is accepted on the following cycle.
- The host never drives data while in ACK or WAIT_IDLE.
- Edges during IDLE are ignored; that traffic belongs to the receiver.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to SEND and on every fall_edge.
  - While in SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses tx_err with code 2'b01 and returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely for the device, and tx_err_code 2'b01 never occurs.

Test Plan:
- Reset mid-SEND (after 4 bits): rst_n low -> ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0 immediately; after release, IDLE accepts tx_start.
- tx_data=0xED with a device model clocking at 12.5 kHz and ACKing:
  - ps2_clk_oe high exactly 5000 cycles.
  - Line bits after start 0: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once and tx_busy falls in that cycle.
- tx_data=0xF4: line bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulses; rx_hold mirrors tx_busy throughout.
- Device leaves data high at the 11th falling edge -> tx_err pulse with tx_err_code=2'b10, lines released, no tx_done.
- tx_start re-asserted with 0x00 while busy sending 0xFF -> ignored; line carries 0xFF, parity 1; exactly one tx_done.
- PS2_TX_TIMEOUT_EN defined, device stops clocking after 3 edges -> tx_err with code 2'b01 exactly TIMEOUT_CYCLES after the last fall_edge. Undefined: tx_busy stays high.
